// File: rtl/scrambler_pkg.sv
// Shared scrambler/descrambler definitions: ordered-set codes, LFSR seed and
// feedback taps, data_len encodings and the descrambler FSM state type.
// Used by both scrambler_top and descrambler_top.
package scrambler_pkg;

    // LFSR value loaded at reset and after every COM symbol
    localparam logic [15:0] SCR_SEED_DEFAULT = 16'hFFFF;

    // Galois feedback for G(X) = X^16+X^5+X^4+X^3+1: the bit shifted out of
    // position 15 is fed back into bits 0, 3, 4 and 5
    localparam logic [15:0] SCR_LFSR_TAPS = 16'h0039;

    // K-code symbols with special LFSR handling
    localparam logic [7:0] SCR_COM = 8'hBC;
    localparam logic [7:0] SCR_SKP = 8'h1C;

    // data_len encodings
    localparam logic [1:0] SCR_LEN_8    = 2'b00;
    localparam logic [1:0] SCR_LEN_16   = 2'b01;
    localparam logic [1:0] SCR_LEN_32   = 2'b10;
    localparam logic [1:0] SCR_LEN_RSVD = 2'b11;

    // Descrambler link-alignment state
    typedef enum logic {
        DESC_UNLOCKED = 1'b0,
        DESC_LOCKED   = 1'b1
    } desc_state_t;

    // Result of processing one byte lane: output symbol, K flag, LFSR and
    // lock state handed on to the next lane
    typedef struct packed {
        logic [7:0]  data;
        logic        k;
        logic [15:0] lfsr;
        logic        locked;
    } byte_res_t;

    // Byte-lane enables for a data_len code; the reserved code enables none
    function automatic logic [3:0] len_active_bytes(input logic [1:0] len);
        logic [3:0] act;
        case (len)
            SCR_LEN_8:  act = 4'b0001;
            SCR_LEN_16: act = 4'b0011;
            SCR_LEN_32: act = 4'b1111;
            default:    act = 4'b0000;
        endcase
        return act;
    endfunction

endpackage

// File: rtl/descrambler_lfsr_byte.sv
// One byte worth of LFSR: advances the scrambler LFSR by 8 steps and returns
// the 8 output bits as a scramble mask (bit 0 = first bit on the wire).
// Purely combinational; the top chains four of these per word.
module descrambler_lfsr_byte
    import scrambler_pkg::*;
(
    input  logic [15:0] lfsr_i,
    output logic [15:0] lfsr_o,
    output logic [7:0]  mask_o
);

    logic [15:0] state_s;

    // Eight serial LFSR steps unrolled; each step emits the MSB as mask bit
    always_comb begin
        state_s = lfsr_i;
        mask_o  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            mask_o[i] = state_s[15];
            if (state_s[15]) begin
                state_s = {state_s[14:0], 1'b0} ^ SCR_LFSR_TAPS;
            end else begin
                state_s = {state_s[14:0], 1'b0};
            end
        end
        lfsr_o = state_s;
    end

endmodule

// File: rtl/descrambler_top.sv
// Gen1/2 byte-oriented descrambler for 8/16/32-bit symbol words.
// Bytes are handled in wire order (byte 0 first) within one cycle; COM reloads
// the LFSR for the following byte, SKP leaves it untouched, every other
// active byte advances it by 8 steps. Data bytes pass raw until the first COM
// aligns the LFSR (UNLOCKED -> LOCKED). One cycle latency, no backpressure.
// Optional feature: define DESCRAMBLER_BYPASS_EN to add bypass_i, which passes
// data bytes raw while the LFSR keeps tracking the stream.
module descrambler_top
    import scrambler_pkg::*;
#(
    parameter logic [15:0] SEED = SCR_SEED_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
`ifdef DESCRAMBLER_BYPASS_EN
    input  logic        bypass_i,
`endif
    input  logic        valid_i,
    input  logic [31:0] indata_i,
    input  logic [3:0]  datak_i,
    input  logic [1:0]  data_len_i,
    output logic        valid_o,
    output logic [31:0] descrambled_data_o,
    output logic [3:0]  datak_o,
    output logic [1:0]  data_len_o,
    output logic        locked_o,
    output logic        len_err_o
);

    // ------------------------------------------------------------------
    // Per-byte processing rule
    // ------------------------------------------------------------------
    function automatic byte_res_t desc_step(
        input logic        active,
        input logic [7:0]  din,
        input logic        kin,
        input logic [15:0] lfsr_cur,
        input logic [15:0] lfsr_adv,
        input logic [7:0]  mask,
        input logic        locked_cur,
        input logic        bypass
    );
        byte_res_t r;
        r.data   = 8'h00;
        r.k      = 1'b0;
        r.lfsr   = lfsr_cur;
        r.locked = locked_cur;
        if (active) begin
            r.k = kin;
            if (kin) begin
                // K symbols are never scrambled
                r.data = din;
                case (din)
                    SCR_COM: begin
                        r.lfsr   = SEED;
                        r.locked = 1'b1;
                    end
                    SCR_SKP: r.lfsr = lfsr_cur;
                    default: r.lfsr = lfsr_adv;
                endcase
            end else begin
                r.lfsr = lfsr_adv;
                if (locked_cur && !bypass) begin
                    r.data = din ^ mask;
                end else begin
                    r.data = din;
                end
            end
        end else begin
            // Lanes beyond data_len are zeroed and leave the LFSR alone
            r.data = 8'h00;
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Registers and next-state signals
    // ------------------------------------------------------------------
    desc_state_t state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        valid_q, valid_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  datak_q, datak_d;
    logic [1:0]  len_q, len_d;
    logic        locked_q, locked_d;
    logic        len_err_q, len_err_d;

    logic        bypass_s;
    logic        word_ok_s;
    logic [3:0]  active_s;
    logic        locked_cur_s;

    logic [15:0] adv0_s, adv1_s, adv2_s, adv3_s;
    logic [7:0]  mask0_s, mask1_s, mask2_s, mask3_s;
    byte_res_t   res0_s, res1_s, res2_s, res3_s;

`ifdef DESCRAMBLER_BYPASS_EN
    assign bypass_s = bypass_i;
`else
    assign bypass_s = 1'b0;
`endif

    assign word_ok_s    = valid_i && (data_len_i != SCR_LEN_RSVD);
    assign active_s     = len_active_bytes(data_len_i);
    assign locked_cur_s = (state_q == DESC_LOCKED);

    // ------------------------------------------------------------------
    // Byte-serial lane chain: each lane sees the LFSR/lock left by the
    // previous lane, so several COM/SKP in one word behave as on the wire
    // ------------------------------------------------------------------
    descrambler_lfsr_byte u_lfsr0 (.lfsr_i(lfsr_q),      .lfsr_o(adv0_s), .mask_o(mask0_s));
    assign res0_s = desc_step(active_s[0], indata_i[7:0], datak_i[0], lfsr_q,
                              adv0_s, mask0_s, locked_cur_s, bypass_s);

    descrambler_lfsr_byte u_lfsr1 (.lfsr_i(res0_s.lfsr), .lfsr_o(adv1_s), .mask_o(mask1_s));
    assign res1_s = desc_step(active_s[1], indata_i[15:8], datak_i[1], res0_s.lfsr,
                              adv1_s, mask1_s, res0_s.locked, bypass_s);

    descrambler_lfsr_byte u_lfsr2 (.lfsr_i(res1_s.lfsr), .lfsr_o(adv2_s), .mask_o(mask2_s));
    assign res2_s = desc_step(active_s[2], indata_i[23:16], datak_i[2], res1_s.lfsr,
                              adv2_s, mask2_s, res1_s.locked, bypass_s);

    descrambler_lfsr_byte u_lfsr3 (.lfsr_i(res2_s.lfsr), .lfsr_o(adv3_s), .mask_o(mask3_s));
    assign res3_s = desc_step(active_s[3], indata_i[31:24], datak_i[3], res2_s.lfsr,
                              adv3_s, mask3_s, res2_s.locked, bypass_s);

    // ------------------------------------------------------------------
    // Lock FSM
    // ------------------------------------------------------------------

    // Next lock state: first accepted word carrying a COM locks, lock is sticky
    always_comb begin
        state_d = state_q;
        case (state_q)
            DESC_UNLOCKED: begin
                if (word_ok_s && res3_s.locked) begin
                    state_d = DESC_LOCKED;
                end else begin
                    state_d = DESC_UNLOCKED;
                end
            end
            DESC_LOCKED: state_d = DESC_LOCKED;
            default:     state_d = DESC_UNLOCKED;
        endcase
    end

    // Lock state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= DESC_UNLOCKED;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------

    // Accept good words, drop reserved-length words with an error pulse, hold otherwise
    always_comb begin
        lfsr_d    = lfsr_q;
        valid_d   = 1'b0;
        len_err_d = 1'b0;
        data_d    = data_q;
        datak_d   = datak_q;
        len_d     = len_q;
        if (word_ok_s) begin
            lfsr_d  = res3_s.lfsr;
            valid_d = 1'b1;
            data_d  = {res3_s.data, res2_s.data, res1_s.data, res0_s.data};
            datak_d = {res3_s.k, res2_s.k, res1_s.k, res0_s.k};
            len_d   = data_len_i;
        end else if (valid_i) begin
            len_err_d = 1'b1;
        end else begin
            lfsr_d = lfsr_q;
        end
        locked_d = (state_d == DESC_LOCKED);
    end

    // Output word, LFSR and status registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            lfsr_q    <= SEED;
            valid_q   <= 1'b0;
            data_q    <= 32'h0000_0000;
            datak_q   <= 4'b0000;
            len_q     <= 2'b00;
            locked_q  <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            lfsr_q    <= lfsr_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            datak_q   <= datak_d;
            len_q     <= len_d;
            locked_q  <= locked_d;
            len_err_q <= len_err_d;
        end
    end

    assign valid_o            = valid_q;
    assign descrambled_data_o = data_q;
    assign datak_o            = datak_q;
    assign data_len_o         = len_q;
    assign locked_o           = locked_q;
    assign len_err_o          = len_err_q;

endmodule
